// File: rtl/sine_cos_pwm.sv
// Converts offset-binary sine/cos samples into complementary PWM pairs with dead time.
// One sample is requested per PWM period through sample_en.
module sine_cos_pwm #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int DEAD     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] sine_in,
    input  logic [WIDTH-1:0] cos_in,
    output logic             sample_en,
    output logic             sin_hi,
    output logic             sin_lo,
    output logic             cos_hi,
    output logic             cos_lo,
    output logic             frame
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [DW-1:0] DLOAD = (DEAD > 0) ? DW'(DEAD - 1) : '0;

    typedef enum logic [2:0] {IDLE, LO_ON, DEAD_H, HI_ON, DEAD_L} state_t;

    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_s, duty_c;
    logic [WIDTH-1:0] duty_eff_s, duty_eff_c;
    logic             tick, load;
    logic             raw_s, raw_c;
    logic [1:0]       raw_v;
    logic [1:0]       hi_q, lo_q;

    state_t           state   [2];
    state_t           state_n [2];
    logic [DW-1:0]    dcnt    [2];
    logic [DW-1:0]    dcnt_n  [2];

    assign tick       = run & (pre_cnt == PRE_LAST);
    assign load       = run & (cnt == '0) & (pre_cnt == '0);
    assign duty_eff_s = load ? sine_in : duty_s;
    assign duty_eff_c = load ? cos_in  : duty_c;
    assign raw_v      = {raw_c, raw_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt   <= '0;
            cnt       <= '0;
            duty_s    <= '0;
            duty_c    <= '0;
            raw_s     <= 1'b0;
            raw_c     <= 1'b0;
            sample_en <= 1'b0;
            frame     <= 1'b0;
        end else if (!run) begin
            pre_cnt   <= '0;
            cnt       <= '0;
            raw_s     <= 1'b0;
            raw_c     <= 1'b0;
            sample_en <= 1'b0;
            frame     <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                duty_s <= sine_in;
                duty_c <= cos_in;
            end
            raw_s     <= (cnt < duty_eff_s);
            raw_c     <= (cnt < duty_eff_c);
            sample_en <= load;
            frame     <= load;
        end
    end

    // dcnt is loaded with DEAD-1 so a side turns on exactly DEAD clocks after the dead state is entered.
    always_comb begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            state_n[ch] = state[ch];
            dcnt_n[ch]  = dcnt[ch];
            if (!run) begin
                state_n[ch] = IDLE;
                dcnt_n[ch]  = '0;
            end else begin
                case (state[ch])
                    IDLE: begin
                        if (DEAD == 0) begin
                            state_n[ch] = raw_v[ch] ? HI_ON : LO_ON;
                        end else begin
                            state_n[ch] = raw_v[ch] ? DEAD_H : DEAD_L;
                            dcnt_n[ch]  = DLOAD;
                        end
                    end
                    LO_ON: begin
                        if (raw_v[ch]) begin
                            state_n[ch] = (DEAD == 0) ? HI_ON : DEAD_H;
                            dcnt_n[ch]  = DLOAD;
                        end
                    end
                    HI_ON: begin
                        if (!raw_v[ch]) begin
                            state_n[ch] = (DEAD == 0) ? LO_ON : DEAD_L;
                            dcnt_n[ch]  = DLOAD;
                        end
                    end
                    DEAD_H: begin
                        if (!raw_v[ch]) begin
                            state_n[ch] = LO_ON;
                        end else if (dcnt[ch] == '0) begin
                            state_n[ch] = HI_ON;
                        end else begin
                            dcnt_n[ch] = dcnt[ch] - 1'b1;
                        end
                    end
                    DEAD_L: begin
                        if (raw_v[ch]) begin
                            state_n[ch] = HI_ON;
                        end else if (dcnt[ch] == '0) begin
                            state_n[ch] = LO_ON;
                        end else begin
                            dcnt_n[ch] = dcnt[ch] - 1'b1;
                        end
                    end
                    default: begin
                        state_n[ch] = IDLE;
                        dcnt_n[ch]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (reset) begin
                state[ch] <= IDLE;
                dcnt[ch]  <= '0;
                hi_q[ch]  <= 1'b0;
                lo_q[ch]  <= 1'b0;
            end else begin
                state[ch] <= state_n[ch];
                dcnt[ch]  <= dcnt_n[ch];
                hi_q[ch]  <= (state_n[ch] == HI_ON);
                lo_q[ch]  <= (state_n[ch] == LO_ON);
            end
        end
    end

    assign sin_hi = hi_q[0];
    assign sin_lo = lo_q[0];
    assign cos_hi = hi_q[1];
    assign cos_lo = lo_q[1];

endmodule
